spi_ram_arbiter: RTL
====================

// Module: spi_ram_arbiter
// PURPOSE
//  Sits between the SPI slave and the single-port RAM, and shares the RAM with a local host port.
//  Decodes 10-bit SPI command words into RAM accesses and keeps the address registers.
//  Returns read data to the slave via tx_data/tx_valid.
//  Arbitrates RAM cycles between the SPI path (fixed priority, cannot stall) and the host req/gnt port.
// PARAMETERS
//  ADDR_WIDTH  8  RAM address width; equals the SPI payload width.
//  DATA_WIDTH  8  RAM word width; equals the SPI payload width.
//  AUTO_INC    0  1: wr_addr/rd_addr +1 (mod 2^ADDR_WIDTH) after each SPI data access.
// PORTS
//  SCK          in   1           clock; all logic on posedge.
//  rst_n        in   1           asynchronous active-low reset.
//  rx_data      in   10          SPI word: [9:8] cmd, [7:0] payload.
//  rx_valid     in   1           1-cycle pulse; rx_data valid.
//  tx_data      out  DATA_WIDTH  read data to slave; held until the next SPI read.
//  tx_valid     out  1           1-cycle pulse; tx_data updated.
//  host_req     in   1           host request; held with fields stable until gnt.
//  host_we      in   1           1 = write, 0 = read.
//  host_addr    in   ADDR_WIDTH  host address.
//  host_wdata   in   DATA_WIDTH  host write data.
//  host_gnt     out  1           1-cycle pulse; host access issued this cycle.
//  host_rdata   out  DATA_WIDTH  host read data.
//  host_rvalid  out  1           1-cycle pulse, one cycle after a read gnt.
//  ram_en       out  1           RAM access strobe.
//  ram_we       out  1           write enable (meaningful only when ram_en=1).
//  ram_addr     out  ADDR_WIDTH  RAM address.
//  ram_wdata    out  DATA_WIDTH  RAM write data.
//  ram_rdata    in   DATA_WIDTH  RAM read data, valid one cycle after ram_en & !ram_we.
//  cmd_err      out  1           1-cycle pulse; SPI data command dropped (no address loaded).
// BEHAVIOUR
//  Reset: all outputs 0; wr_addr, rd_addr and tx_data 0; flags wr_av/rd_av 0; state IDLE.
//  Reset mid-access aborts it: no tx_valid/host_rvalid afterwards.
//  SPI cmd on rx_valid:
//   00 WR_ADDR: wr_addr<=payload; wr_av<=1; no RAM cycle.
//   01 WR_DATA: if wr_av, RAM write to wr_addr in the SAME cycle (ram_en=ram_we=1); else cmd_err.
//   10 RD_ADDR: rd_addr<=payload; rd_av<=1; no RAM cycle.
//   11 RD_DATA: if rd_av, RAM read of rd_addr in the same cycle; next cycle tx_data<=ram_rdata
//     and tx_valid=1; else cmd_err.
//  wr_av/rd_av stay set until reset; AUTO_INC applies only to successful data cmds; 8'hFF wraps to 00.
//  Arbitration, per cycle: SPI data cmd > host_req > idle. At most one RAM access per cycle.
//   Host loses only in cycles carrying an SPI data cmd; its req stays pending.
//   SPI cmds are spaced >=10 SCK cycles apart, so host wait is <=1 cycle.
//  host_gnt: combinational on cycles the host wins, with ram_* driven from the host fields.
//   Read gnt -> host_rvalid + host_rdata next cycle.
//   Back-to-back host grants are allowed (one per cycle while req=1).
//  FSM (registered):
//   IDLE -> SPI_RD (SPI read issued) -> IDLE, driving tx_valid.
//   IDLE -> HOST_RD (host read issued) -> IDLE, driving host_rvalid.
//   Writes never leave IDLE.
//   A new access may issue in the SPI_RD/HOST_RD cycle, pipelined back to IDLE or a read state.
//  ram_addr/ram_wdata/ram_we are 0 when ram_en=0.
// STRUCTURE
//  spi_ram_pkg: typedef enum logic[1:0] {WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10,
//   RD_DATA=2'b11} spi_cmd_e; typedef enum {IDLE, SPI_RD, HOST_RD} arb_state_e.
//  Sub-module spi_cmd_decoder: rx_data/rx_valid -> address registers, wr_av/rd_av flags and a
//   one-cycle SPI request. Arbiter and FSM stay in the top module.
// TESTING
//  1 WR_ADDR 0x10, then WR_DATA 0xA5 -> ram_en=ram_we=1, addr 0x10, wdata 0xA5 in the rx_valid cycle.
//  2 RD_ADDR 0x10, then RD_DATA -> ram read of 0x10; next cycle tx_valid=1, tx_data=0xA5.
//  3 After reset, RD_DATA with no RD_ADDR -> cmd_err=1, ram_en=0, tx_valid=0.
//  4 host_req read of 0x20 held in the same cycle as an SPI WR_DATA -> host_gnt=0 that cycle,
//    =1 next cycle; host_rvalid one cycle after gnt.
//  5 AUTO_INC=1: WR_ADDR 0xFF, then two WR_DATA -> writes to 0xFF, then 0x00.
//  6 rst_n low during the SPI_RD cycle -> tx_valid stays 0, all outputs 0.
//    After release, the first RD_DATA gives cmd_err.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-to-RAM bridge: SPI command word layout and arbiter states.
package spi_ram_pkg;

  localparam int unsigned RX_W      = 10;
  localparam int unsigned PAYLOAD_W = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPI_RD  = 2'd1,
    HOST_RD = 2'd2
  } arb_state_e;

  typedef struct packed {
    spi_cmd_e               cmd;
    logic [PAYLOAD_W-1:0]   payload;
  } spi_word_t;

  // Data commands have cmd[0] set; cmd[1] selects the read side.
  function automatic logic is_data_cmd(input spi_cmd_e cmd);
    return cmd[0];
  endfunction

  function automatic logic is_read_cmd(input spi_cmd_e cmd);
    return cmd[1];
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Host request/grant port sharing the RAM with the SPI path.
interface spi_ram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_gnt;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  host_rvalid;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid
  );

endinterface

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI command words: keeps the write/read address registers and their
// valid flags, and raises a same-cycle RAM request for accepted data commands.
module spi_cmd_decoder
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AUTO_INC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [RX_W-1:0]       rx_data,
  input  logic                  rx_valid,
  output logic                  spi_req,
  output logic                  spi_we,
  output logic [ADDR_WIDTH-1:0] spi_addr,
  output logic [DATA_WIDTH-1:0] spi_wdata,
  output logic                  cmd_err
);

  spi_word_t             word;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_av;
  logic                  rd_av;
  logic                  addr_ok;

  assign word    = spi_word_t'(rx_data);
  assign addr_ok = is_read_cmd(word.cmd) ? rd_av : wr_av;

  // Data commands without a loaded address are dropped and flagged.
  always_comb begin
    spi_req   = 1'b0;
    spi_we    = 1'b0;
    spi_addr  = '0;
    spi_wdata = '0;
    cmd_err   = 1'b0;
    if (rx_valid && is_data_cmd(word.cmd)) begin
      if (addr_ok) begin
        spi_req = 1'b1;
        if (is_read_cmd(word.cmd)) begin
          spi_addr = rd_addr;
        end else begin
          spi_we    = 1'b1;
          spi_addr  = wr_addr;
          spi_wdata = DATA_WIDTH'(word.payload);
        end
      end else begin
        cmd_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
      wr_av   <= 1'b0;
      rd_av   <= 1'b0;
    end else if (rx_valid) begin
      case (word.cmd)
        WR_ADDR: begin
          wr_addr <= ADDR_WIDTH'(word.payload);
          wr_av   <= 1'b1;
        end
        RD_ADDR: begin
          rd_addr <= ADDR_WIDTH'(word.payload);
          rd_av   <= 1'b1;
        end
        WR_DATA: if (wr_av && AUTO_INC != 0) wr_addr <= wr_addr + ADDR_WIDTH'(1);
        RD_DATA: if (rd_av && AUTO_INC != 0) rd_addr <= rd_addr + ADDR_WIDTH'(1);
      endcase
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares a single-port RAM between the SPI command path (fixed priority) and a
// host req/gnt port; returns SPI read data on tx_data and host data on host_rdata.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AUTO_INC   = 0
) (
  input  logic                  SCK,
  input  logic                  rst_n,
  input  logic [RX_W-1:0]       rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  spi_ram_arbiter_if.slave      host,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  cmd_err
);

  logic                  spi_req;
  logic                  spi_we;
  logic [ADDR_WIDTH-1:0] spi_addr;
  logic [DATA_WIDTH-1:0] spi_wdata;
  logic                  gnt;
  arb_state_e            state;
  logic [DATA_WIDTH-1:0] tx_hold;

  spi_cmd_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AUTO_INC   (AUTO_INC)
  ) u_dec (
    .clk       (SCK),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .spi_req   (spi_req),
    .spi_we    (spi_we),
    .spi_addr  (spi_addr),
    .spi_wdata (spi_wdata),
    .cmd_err   (cmd_err)
  );

  // SPI data commands win; the host gets the RAM in any other cycle it asks.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    gnt       = 1'b0;
    if (spi_req) begin
      ram_en    = 1'b1;
      ram_we    = spi_we;
      ram_addr  = spi_addr;
      ram_wdata = spi_wdata;
    end else if (host.host_req) begin
      ram_en    = 1'b1;
      ram_we    = host.host_we;
      ram_addr  = host.host_addr;
      ram_wdata = host.host_we ? host.host_wdata : '0;
      gnt       = 1'b1;
    end
  end

  // Read states mark the cycle in which ram_rdata belongs to the previous reader.
  always_ff @(posedge SCK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_hold <= '0;
    end else begin
      if (state == SPI_RD) tx_hold <= ram_rdata;
      if (spi_req && !spi_we) begin
        state <= SPI_RD;
      end else if (gnt && !host.host_we) begin
        state <= HOST_RD;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign tx_valid         = (state == SPI_RD);
  assign tx_data          = tx_valid ? ram_rdata : tx_hold;
  assign host.host_gnt    = gnt;
  assign host.host_rvalid = (state == HOST_RD);
  assign host.host_rdata  = (state == HOST_RD) ? ram_rdata : '0;

endmodule
